// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency block read/write main memory with a word-per-cycle burst and a Done pulse.
// Unwritten words read back as their own word address, which gives the power-on image without a preload.
module main_memory_responder #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 3,
    localparam int IDX_W      = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cache_req,
    input  logic              cache_rOw,
    input  logic [ADDR_W-1:0] cache_address,
    input  logic [DATA_W-1:0] cache_writeData,
    output logic [DATA_W-1:0] main_readData,
    output logic              main_valid,
    output logic [IDX_W-1:0]  main_wordIdx,
    output logic              busy,
    output logic              Done
);
    localparam int WA_W  = ADDR_W - 2;
    localparam int WORDS = 2 ** WA_W;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WA_W-1:0]   base_q, base_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] mem_q [WORDS];
    logic              wr_q [WORDS] = '{default: 1'b0};
    logic [WA_W-1:0]   waddr;
    logic              xfer;

    assign waddr = base_q | WA_W'(idx_q);
    assign xfer  = state_q == XFER;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        base_d  = base_q;
        rw_d    = rw_q;
        case (state_q)
            IDLE: if (cache_req) begin
                state_d = WAIT;
                cnt_d   = '0;
                base_d  = cache_address[ADDR_W-1:2] & ~WA_W'(BLOCK_WORDS - 1);
                rw_d    = cache_rOw;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d = XFER;
                    idx_d   = '0;
                end
            end
            XFER: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(BLOCK_WORDS - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            base_q  <= '0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            rw_q    <= rw_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset_n.
    always_ff @(posedge clock) begin
        if (xfer && rw_q) begin
            mem_q[waddr] <= cache_writeData;
            wr_q[waddr]  <= 1'b1;
        end
    end

    assign busy          = state_q != IDLE;
    assign Done          = state_q == DONE;
    assign main_valid    = xfer && !rw_q;
    assign main_wordIdx  = idx_q;
    assign main_readData = !main_valid ? '0 : wr_q[waddr] ? mem_q[waddr] : DATA_W'(waddr);
endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: randomized transactions checked cycle by cycle against an array model of memory.
module tb_main_memory_responder;
    localparam int LAT = 3;
    localparam int BW  = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        cache_req = 1'b0;
    logic        cache_rOw = 1'b0;
    logic [9:0]  cache_address = '0;
    logic [31:0] cache_writeData = '0;
    logic [31:0] main_readData;
    logic        main_valid;
    logic [1:0]  main_wordIdx;
    logic        busy;
    logic        Done;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model [256];

    main_memory_responder dut (
        .clock(clock), .reset_n(reset_n), .cache_req(cache_req), .cache_rOw(cache_rOw),
        .cache_address(cache_address), .cache_writeData(cache_writeData),
        .main_readData(main_readData), .main_valid(main_valid), .main_wordIdx(main_wordIdx),
        .busy(busy), .Done(Done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(Done), 0);
        chk({tag, "_valid"}, 32'(main_valid), 0);
        chk({tag, "_rdata"}, main_readData, 0);
        chk({tag, "_idx"}, 32'(main_wordIdx), 0);
    endtask

    // One request; abort_at >= 0 drops reset_n once that many write words have been stored.
    task automatic run_txn(input bit rw, input logic [9:0] addr, input logic [31:0] wbase,
                           input bit hold, input int abort_at);
        int base;
        base = int'(addr >> 2) & ~(BW - 1);
        cache_req     = 1'b1;
        cache_rOw     = rw;
        cache_address = addr;
        cycle();
        for (int c = 0; c <= LAT + BW; c++) begin
            bit x;
            bit d;
            int i;
            x = c >= LAT && c < LAT + BW;
            d = c == LAT + BW;
            i = c - LAT;
            if (rw && x && i == abort_at) begin
                reset_n = 1'b0;
                #1;
                chk_idle("abort");
                cycle();
                reset_n   = 1'b1;
                cache_req = 1'b0;
                return;
            end
            chk("busy", 32'(busy), 1);
            chk("done", 32'(Done), 32'(d));
            chk("valid", 32'(main_valid), 32'(x && !rw));
            chk("rdata", main_readData, (x && !rw) ? model[base + i] : 32'h0);
            if (x) chk("idx", 32'(main_wordIdx), 32'(i));
            if (x && rw) begin
                cache_writeData  = wbase + 32'(i);
                model[base + i]  = wbase + 32'(i);
            end
            if (!hold) begin
                cache_req     = (c == 0 || d) ? 1'b1 : 1'($urandom_range(0, 1));
                cache_rOw     = 1'($urandom);
                cache_address = 10'($urandom);
            end
            cycle();
        end
        chk("busy_after", 32'(busy), 0);
        chk("done_after", 32'(Done), 0);
        if (!hold) cache_req = 1'b0;
    endtask

    initial begin
        for (int w = 0; w < 256; w++) model[w] = 32'(w);
        #1 reset_n = 1'b0;
        #1 chk_idle("in_reset");
        repeat (2) cycle();
        reset_n = 1'b1;
        #1 chk_idle("post_reset");
        cycle();
        chk_idle("idle_no_req");

        run_txn(1'b0, 10'h024, 32'h0, 1'b0, -1);
        run_txn(1'b1, 10'h3F4, 32'hAABB0000, 1'b0, -1);
        run_txn(1'b0, 10'h3F0, 32'h0, 1'b0, -1);
        run_txn(1'b0, 10'h3E0, 32'h0, 1'b0, -1);
        run_txn(1'b1, 10'h040, 32'h11110000, 1'b0, 2);
        chk_idle("after_abort");
        run_txn(1'b0, 10'h040, 32'h0, 1'b0, -1);

        repeat (3) run_txn(1'b0, 10'h000, 32'h0, 1'b1, -1);
        cache_req = 1'b0;

        repeat (30) run_txn(1'($urandom_range(0, 1)), 10'($urandom), $urandom,
                            1'($urandom_range(0, 1)), -1);
        cache_req = 1'b0;
        for (int b = 0; b < 256; b += 4 * 16) run_txn(1'b0, 10'(b * 4), 32'h0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Multi-cycle main memory that serves the cache's miss traffic: one block read or one block write per request, with a fixed access latency.
- Uses a request/Done handshake and a per-word burst.
- Sits on the memory side of the cache-to-main-memory interface, replacing the zero-latency combinational memory model so cache FSMs can be exercised against realistic stalls.
- Word-addressed storage with byte addresses on the bus.

Parameters:
- ADDR_W, 10, byte-address width of cache_address.
- DATA_W, 32, word width.
- BLOCK_WORDS, 4, words per cache block; power of two, ≥1.
- LATENCY, 3, cycles spent in WAIT before the first data word; ≥1.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cache_req  input  1  request strobe, sampled only in IDLE.
- cache_rOw  input  1  0 = block read, 1 = block write; latched with request.
- cache_address  input  ADDR_W  byte address; block-aligned internally.
- cache_writeData  input  DATA_W  write word selected by main_wordIdx; sampled during XFER.
- main_readData  output  DATA_W  read word for current main_wordIdx; 0 when main_valid=0.
- main_valid  output  1  read word valid this cycle.
- main_wordIdx  output  log2(BLOCK_WORDS) (min 1)  word index within block being transferred.
- busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Storage: 2^ADDR_W/4 words. At simulation start, word w holds value w. reset_n does not alter contents.
- Address split:
  - base = cache_address with low log2(4*BLOCK_WORDS) bits cleared.
  - word address = base/4 + main_wordIdx.
  - Bursts never cross a block, so there is no wrap.
- States: IDLE, WAIT, XFER, DONE.
- IDLE:
  - A posedge with cache_req=1 latches base and cache_rOw, clears the latency counter, and moves to WAIT.
  - cache_req=0 stays in IDLE.
- WAIT: counts LATENCY cycles, then moves to XFER with wordIdx=0.
- XFER: lasts exactly BLOCK_WORDS cycles, and wordIdx increments each posedge.
  - Read: main_readData = mem[word address] combinationally; main_valid=1.
  - Write: at each posedge, mem[word address] <= cache_writeData; main_valid stays 0.
  - Leaves after the last word, moving to DONE.
- DONE: Done=1 for exactly one cycle, busy=1, then unconditionally back to IDLE.
- Latency: a request sampled at edge k gives WAIT for cycles k+1..k+LATENCY, XFER for the next BLOCK_WORDS cycles, and Done high in the cycle after edge k+LATENCY+BLOCK_WORDS.
  - For LATENCY=3 and BLOCK_WORDS=4, Done is high 8 cycles after acceptance.
- cache_req while busy=1 (including the DONE cycle) is ignored and not queued. A new request is accepted at the first posedge in IDLE.
- Changes to cache_rOw and cache_address after acceptance have no effect.
- Outputs are combinational decodes of the registered state, idx and latches.
- Reset values: state=IDLE, counters 0, busy=0, Done=0, main_valid=0, main_wordIdx=0, main_readData=0.
- Reset mid-operation: asynchronous return to IDLE. Words already written in a partial write burst remain; the remaining words are unchanged. No Done is produced for the aborted request.

Test Plan:
- All tests use defaults.
- Reset then idle: hold reset_n=0 for 2 cycles, then release -> busy=0, Done=0, main_valid=0, main_readData=0.
- Block read: req, rOw=0, addr 0x024 -> base 0x020.
  - busy=1 from the next cycle.
  - 3 WAIT cycles, then main_valid=1 for 4 cycles with data 0x00000008, 09, 0A, 0B.
  - Done pulse 8 cycles after acceptance, then busy=0.
- Block write then readback: write to addr 0x3F4 with the bench driving 0xAABB0000+main_wordIdx -> Done after 8 cycles.
  - Read of 0x3F0 returns AABB0000..AABB0003.
  - Read of 0x3E0 still returns 0xF8..0xFB.
- Request during busy: pulse cache_req (read 0x100) in a WAIT cycle and in the DONE cycle -> ignored, no second burst. A req held high into IDLE is accepted at the first IDLE posedge.
- Reset mid-write: write 0x040 with data 0x11110000+idx, drop reset_n after 2 XFER edges -> immediate IDLE with outputs 0.
  - Readback of 0x040 returns 11110000, 11110001, 0x12, 0x13.
- Back-to-back: hold cache_req=1 continuously (read 0x000) -> exactly one Done per 9 cycles, with busy low for one cycle between requests.
